qk_mac_sequencer: RTL and testbench
===================================

Name: qk_mac_sequencer

Overview:
- Controller that drives the 19-bit `inst` word and `mem_in` bus of the Q/K MAC array top.
- Sequences one job end to end:
  1. Stream K vectors into kmem and Q vectors into qmem.
  2. Preload K rows into the MAC array.
  3. Stream Q rows through the array in execute mode.
  4. Drain the ofifo.
- Sole owner of `inst`; the testbench/host only supplies the data stream and a start pulse.

Parameters:
- `bw`, 8, bits per element.
- `pr`, 8, elements per vector; `mem_in` width is `pr*bw`.
- `aw`, 4, qmem/kmem address width; depth is 2**aw = 16.
- `drain`, 4, idle cycles between last execute and first ofifo read (array pipeline flush).

Ports:
- `clk`, in, 1, clock.
- `reset`, in, 1, synchronous, active-low; `reset==0` at a rising edge resets.
- `start`, in, 1, one-cycle job request, sampled only in IDLE.
- `k_len`, in, aw+1, K rows 1..16, captured at `start`.
- `q_len`, in, aw+1, Q rows 1..16, captured at `start`.
- `in_data`, in, pr*bw, host vector stream.
- `in_valid`, in, 1, `in_data` valid.
- `in_ready`, out, 1, sequencer accepts `in_data` this cycle.
- `fifo_valid`, in, 1, ofifo o_valid.
- `inst`, out, 19, registered instruction word to the MAC top.
- `mem_in`, out, pr*bw, registered write data to qmem/kmem.
- `busy`, out, 1, high in any state other than IDLE.
- `done`, out, 1, one-cycle pulse after the last ofifo read.

Behaviour:
- **inst fields** (all unlisted bits 0):
  - [16] ofifo_rd; [15:12] address.
  - [7] execute; [6] kernel-load, which also selects kmem as array input.
  - [5] qmem_rd; [4] qmem_wr; [3] kmem_rd; [2] kmem_wr.
- **Reset:** `inst=0`, `mem_in=0`, `in_ready=0`, `busy=0`, `done=0`, state IDLE, counters 0. Reset mid-job aborts immediately; there is no partial completion.
- **`k_len`/`q_len` range:** a value of 0 or >16 at `start` is clamped to 16.
- **Registered outputs:** `inst` and `mem_in` are registered, so the state decoded in cycle t appears on the ports at t+1. All latencies below are at the ports.
- **IDLE:** `in_ready=0`. On `start`: capture lengths, clear counter `c`, go to WR_K.
- **WR_K:**
  - `in_ready=1`.
  - Each handshake (`in_valid & in_ready`) registers `mem_in=in_data` and `inst[2]=1`, `inst[15:12]=c`; then `c++`.
  - With no handshake, `inst=0`; bubbles are allowed.
  - After the `k_len`-th handshake: `c=0`, go to WR_Q.
- **WR_Q:** identical to WR_K but uses `inst[4]`; after `q_len` handshakes go to KLD. `in_ready` drops in the cycle after the final handshake.
- **KLD:**
  - Cycle k (0..`k_len`-1) issues `inst[3]=1`, addr k.
  - Because SRAM read data arrives one cycle later, `inst[6]=1` is asserted in the cycle after each read. For k>0 it overlaps the next read.
  - `kmem_rd` and `inst[6]` are therefore both high during the middle cycles.
  - Total KLD span is `k_len+1` cycles, then go to EXE.
- **EXE:** same pattern with `inst[5]` (qmem_rd, addr j) followed one cycle later by `inst[7]`. Span `q_len+1` cycles, then go to DRN.
- **DRN:** `inst=0` for `drain` cycles, then go to RD.
- **RD:**
  - `inst[16] = fifo_valid`, evaluated each cycle; count reads.
  - After `q_len` reads: `done=1` for one cycle, go to IDLE.
  - `fifo_valid` low stalls indefinitely; there is no timeout.
- **Overlaps and boundaries:**
  - `start` while `busy` is ignored.
  - The address counter never wraps inside a phase, since the max count of 16 fits `aw` bits with index 0..15.
  - `kmem_wr` and `qmem_wr` are never high simultaneously.
  - A read strobe and a write strobe to the same memory are never both high.

Decomposition:
- Shared package `qk_pkg`:
  - inst bit-index localparams: OFIFO_RD=16, ADDR_LSB=12, EXE=7, KLD=6, QRD=5, QWR=4, KRD=3, KWR=2.
  - State enum: IDLE, WR_K, WR_Q, KLD, EXE, DRN, RD.
- One natural sub-module, `qk_rd_pipe`:
  - Generates the read-then-use pair (mem read at t, array strobe at t+1) for a given length.
  - Instantiated once and shared by KLD and EXE via a select input.

Test Plan:
- **Basic job:** reset low 2 cycles, then `start` with `k_len=8`, `q_len=8`, `in_valid` always 1.
  - Expect 8 `kmem_wr` at addr 0..7, then 8 `qmem_wr` at addr 0..7.
  - KLD: `inst[3]` at addr 0..7, with `inst[6]` lagging by 1 cycle.
  - EXE: `inst[5]`/`inst[7]` with the same 1-cycle lag.
  - 4 idle cycles, then 8 `inst[16]`, then `done` exactly once.
- **Backpressure:** `in_valid` toggled 1,0,0,1 with `k_len=2`, `q_len=1`.
  - Expect `kmem_wr` only on valid cycles at addr 0,1.
  - `mem_in` equals the accepted data.
  - No writes on bubble cycles.
- **Boundary lengths:**
  - `k_len=16`, `q_len=1`: addresses reach 15 with no wrap; EXE spans 2 cycles.
  - `k_len=0`: behaves as 16.
- **ofifo stall:** in RD, hold `fifo_valid=0` for 5 cycles.
  - Expect `inst[16]=0` throughout the stall and no `done`.
  - Once `fifo_valid=1`, reads resume and the count completes.
- **Reset mid-EXE:** assert reset at EXE cycle 3.
  - Expect `inst=0`, `busy=0` on the next cycle.
  - A new `start` runs a full clean job.
- **Start while busy:** pulse `start` during WR_Q with different lengths.
  - Expect it ignored; the original lengths govern the job.

Source files
------------

// File: rtl/qk_pkg.sv
// Shared definitions for the Q/K MAC sequencer: instruction bit positions and controller states.
package qk_pkg;

  localparam int INST_W   = 19;
  localparam int OFIFO_RD = 16;
  localparam int ADDR_LSB = 12;
  localparam int EXE      = 7;
  localparam int KLD      = 6;
  localparam int QRD      = 5;
  localparam int QWR      = 4;
  localparam int KRD      = 3;
  localparam int KWR      = 2;

  // State names carry a prefix so they do not collide with the bit-index names above.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_K,
    ST_WR_Q,
    ST_KLD,
    ST_EXE,
    ST_DRN,
    ST_RD
  } state_t;

endpackage

// File: rtl/qk_rd_pipe.sv
// Read-then-use generator: memory read strobe at cycle k, array strobe at k+1, for len reads.
module qk_rd_pipe #(
  parameter int aw = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_active,
  input  logic          i_sel,
  input  logic [aw:0]   i_k_len,
  input  logic [aw:0]   i_q_len,
  output logic          o_rd,
  output logic          o_use,
  output logic          o_last,
  output logic [aw-1:0] o_addr
);

  logic [aw:0] r_cnt;
  logic [aw:0] w_len;

  assign w_len  = i_sel ? i_q_len : i_k_len;
  assign o_rd   = i_active && (r_cnt < w_len);
  assign o_use  = i_active && (r_cnt != '0);
  assign o_last = i_active && (r_cnt == w_len);
  assign o_addr = r_cnt[aw-1:0];

  // Restarting at the last cycle lets the next phase begin at count 0 with no gap.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (!i_active || o_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/qk_mac_sequencer.sv
// Job sequencer for the Q/K MAC array: load kmem/qmem, preload K, execute Q, drain, read ofifo.
module qk_mac_sequencer
  import qk_pkg::*;
#(
  parameter int bw    = 8,
  parameter int pr    = 8,
  parameter int aw    = 4,
  parameter int drain = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [aw:0]       k_len,
  input  logic [aw:0]       q_len,
  input  logic [pr*bw-1:0]  in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              fifo_valid,
  output logic [INST_W-1:0] inst,
  output logic [pr*bw-1:0]  mem_in,
  output logic              busy,
  output logic              done
);

  localparam logic [aw:0] DEPTH      = (aw+1)'(2**aw);
  localparam logic [aw:0] DRAIN_LAST = (aw+1)'(drain-1);

  state_t              r_state, w_state_next;
  logic [aw:0]         r_k_len, w_k_len_next;
  logic [aw:0]         r_q_len, w_q_len_next;
  logic [aw:0]         r_cnt, w_cnt_next;
  logic [INST_W-1:0]   r_inst, w_inst_next;
  logic [pr*bw-1:0]    r_mem_in, w_mem_in_next;
  logic                r_done, w_done_next;

  logic                w_hs;
  logic                w_k_last;
  logic                w_q_last;
  logic                w_pipe_active;
  logic                w_pipe_rd;
  logic                w_pipe_use;
  logic                w_pipe_last;
  logic [aw-1:0]       w_pipe_addr;

  function automatic logic [aw:0] clamp_len(input logic [aw:0] l);
    return ((l == '0) || (l > DEPTH)) ? DEPTH : l;
  endfunction

  assign in_ready = (r_state == ST_WR_K) || (r_state == ST_WR_Q);
  assign busy     = (r_state != ST_IDLE);
  assign inst     = r_inst;
  assign mem_in   = r_mem_in;
  assign done     = r_done;

  assign w_hs          = in_valid && in_ready;
  assign w_k_last      = (r_cnt == r_k_len - 1'b1);
  assign w_q_last      = (r_cnt == r_q_len - 1'b1);
  assign w_pipe_active = (r_state == ST_KLD) || (r_state == ST_EXE);

  qk_rd_pipe #(.aw(aw)) u_rd_pipe (
    .clk      (clk),
    .reset    (reset),
    .i_active (w_pipe_active),
    .i_sel    (r_state == ST_EXE),
    .i_k_len  (r_k_len),
    .i_q_len  (r_q_len),
    .o_rd     (w_pipe_rd),
    .o_use    (w_pipe_use),
    .o_last   (w_pipe_last),
    .o_addr   (w_pipe_addr)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_k_len  <= '0;
      r_q_len  <= '0;
      r_cnt    <= '0;
      r_inst   <= '0;
      r_mem_in <= '0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_k_len  <= w_k_len_next;
      r_q_len  <= w_q_len_next;
      r_cnt    <= w_cnt_next;
      r_inst   <= w_inst_next;
      r_mem_in <= w_mem_in_next;
      r_done   <= w_done_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (start)                      w_state_next = ST_WR_K;
      ST_WR_K: if (w_hs && w_k_last)           w_state_next = ST_WR_Q;
      ST_WR_Q: if (w_hs && w_q_last)           w_state_next = ST_KLD;
      ST_KLD:  if (w_pipe_last)                w_state_next = ST_EXE;
      ST_EXE:  if (w_pipe_last)                w_state_next = ST_DRN;
      ST_DRN:  if (r_cnt == DRAIN_LAST)        w_state_next = ST_RD;
      ST_RD:   if (fifo_valid && w_q_last)     w_state_next = ST_IDLE;
      default:                                 w_state_next = ST_IDLE;
    endcase
  end

  // Everything computed here lands on the ports one cycle later.
  always_comb begin
    w_inst_next   = '0;
    w_mem_in_next = r_mem_in;
    w_done_next   = 1'b0;
    w_cnt_next    = r_cnt;
    w_k_len_next  = r_k_len;
    w_q_len_next  = r_q_len;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_k_len_next = clamp_len(k_len);
          w_q_len_next = clamp_len(q_len);
          w_cnt_next   = '0;
        end
      end
      ST_WR_K, ST_WR_Q: begin
        if (w_hs) begin
          w_inst_next[(r_state == ST_WR_K) ? KWR : QWR] = 1'b1;
          w_inst_next[ADDR_LSB +: aw] = r_cnt[aw-1:0];
          w_mem_in_next = in_data;
          if ((r_state == ST_WR_K) ? w_k_last : w_q_last) begin
            w_cnt_next = '0;
          end else begin
            w_cnt_next = r_cnt + 1'b1;
          end
        end
      end
      ST_KLD, ST_EXE: begin
        w_inst_next[(r_state == ST_KLD) ? KRD : QRD] = w_pipe_rd;
        w_inst_next[(r_state == ST_KLD) ? KLD : EXE] = w_pipe_use;
        if (w_pipe_rd) begin
          w_inst_next[ADDR_LSB +: aw] = w_pipe_addr;
        end
      end
      ST_DRN: begin
        w_cnt_next = (r_cnt == DRAIN_LAST) ? '0 : r_cnt + 1'b1;
      end
      ST_RD: begin
        w_inst_next[OFIFO_RD] = fifo_valid;
        if (fifo_valid) begin
          if (w_q_last) begin
            w_done_next = 1'b1;
            w_cnt_next  = '0;
          end else begin
            w_cnt_next = r_cnt + 1'b1;
          end
        end
      end
      default: begin
        w_inst_next = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_qk_mac_sequencer.sv
// Bench for qk_mac_sequencer: per-job expected port trace built from phase arithmetic.
module tb_qk_mac_sequencer;
  import qk_pkg::*;

  localparam int BW    = 8;
  localparam int PR    = 8;
  localparam int AW    = 4;
  localparam int DRAIN = 4;
  localparam int DW    = PR*BW;
  localparam int MAXP  = 400;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW:0]   k_len;
  logic [AW:0]   q_len;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic          fifo_valid;
  logic [18:0]   inst;
  logic [DW-1:0] mem_in;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  qk_mac_sequencer #(.bw(BW), .pr(PR), .aw(AW), .drain(DRAIN)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .k_len      (k_len),
    .q_len      (q_len),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .fifo_valid (fifo_valid),
    .inst       (inst),
    .mem_in     (mem_in),
    .busy       (busy),
    .done       (done)
  );

  // Per-period stimulus and expected port values; period 0 is the cycle start is driven.
  logic          vld   [MAXP];
  logic [DW-1:0] dat   [MAXP];
  logic          fv    [MAXP];
  logic [18:0]   e_inst[MAXP];
  logic [DW-1:0] e_mem [MAXP];
  logic          e_mchk[MAXP];
  logic          e_busy[MAXP];
  logic          e_rdy [MAXP];
  logic          e_done[MAXP];
  int            acc_p [32];

  task automatic run_job(input string name, input int kl_in, input int ql_in,
                         input int vmode, input int fmode, input bit busy_start,
                         input int rst_cyc);
    int kl, ql, n, L, B, E, R0, F, r, p, sp, rp, endp, jerr;
    kl = (kl_in == 0 || kl_in > 16) ? 16 : kl_in;
    ql = (ql_in == 0 || ql_in > 16) ? 16 : ql_in;
    for (int i = 0; i < MAXP; i++) begin
      case (vmode)
        0:       vld[i] = 1'b1;
        1:       vld[i] = !(i == 2 || i == 3);
        default: vld[i] = ($urandom_range(3, 0) != 0);
      endcase
      dat[i]    = {$urandom, $urandom};
      fv[i]     = (fmode == 2) ? 1'($urandom_range(1, 0)) : 1'b1;
      e_inst[i] = '0;
      e_mem[i]  = '0;
      e_mchk[i] = 1'b0;
      e_busy[i] = 1'b0;
      e_rdy[i]  = 1'b0;
      e_done[i] = 1'b0;
    end
    // Words are accepted on the first kl+ql valid cycles after start.
    n = 0;
    for (int i = 1; i < MAXP && n < kl + ql; i++) begin
      if (vld[i]) begin
        acc_p[n] = i;
        n++;
      end
    end
    L = acc_p[kl+ql-1];
    for (int i = 1; i <= L; i++) e_rdy[i] = 1'b1;
    for (int i = 0; i < kl + ql; i++) begin
      p = acc_p[i] + 1;
      e_inst[p][(i < kl) ? KWR : QWR] = 1'b1;
      e_inst[p][15:12] = 4'((i < kl) ? i : i - kl);
      e_mem[p]  = dat[acc_p[i]];
      e_mchk[p] = 1'b1;
    end
    B = L + 1;
    for (int i = 0; i <= kl; i++) begin
      p = B + i + 1;
      if (i < kl) begin
        e_inst[p][KRD]   = 1'b1;
        e_inst[p][15:12] = 4'(i);
      end
      if (i > 0) e_inst[p][KLD] = 1'b1;
    end
    E = B + kl + 1;
    for (int j = 0; j <= ql; j++) begin
      p = E + j + 1;
      if (j < ql) begin
        e_inst[p][QRD]   = 1'b1;
        e_inst[p][15:12] = 4'(j);
      end
      if (j > 0) e_inst[p][EXE] = 1'b1;
    end
    R0 = E + ql + 1 + DRAIN;
    if (fmode == 1) for (int i = R0; i < R0 + 5; i++) fv[i] = 1'b0;
    r = 0;
    p = R0;
    F = MAXP - 3;
    while (r < ql && p < MAXP - 2) begin
      if (fv[p]) begin
        e_inst[p+1][OFIFO_RD] = 1'b1;
        r++;
        if (r == ql) F = p;
      end
      p++;
    end
    e_done[F+1] = 1'b1;
    for (int i = 1; i <= F; i++) e_busy[i] = 1'b1;
    endp = F + 2;
    sp = busy_start ? acc_p[kl-1] + 1 : -1;
    rp = (rst_cyc >= 0) ? E + rst_cyc : -1;
    if (rp >= 0) endp = rp + 1;

    jerr = errors;
    for (p = 0; p <= endp; p++) begin
      @(posedge clk);
      #1;
      reset      = (p == rp) ? 1'b0 : 1'b1;
      start      = (p == 0) || (p == sp);
      k_len      = (p == 0) ? 5'(kl_in) : 5'((kl % 16) + 1);
      q_len      = (p == 0) ? 5'(ql_in) : 5'((ql % 16) + 1);
      in_valid   = vld[p];
      in_data    = dat[p];
      fifo_valid = fv[p];
      @(negedge clk);
      if (rp >= 0 && p == rp + 1) begin
        checks++;
        if (inst !== '0 || busy !== 1'b0 || in_ready !== 1'b0 || done !== 1'b0 || mem_in !== '0) begin
          errors++;
          $display("FAIL %s after_reset inst=%h busy=%b rdy=%b done=%b mem_in=%h expected all zero",
                   name, inst, busy, in_ready, done, mem_in);
        end
      end else begin
        checks++;
        if (inst !== e_inst[p]) begin
          errors++;
          $display("FAIL %s inst p=%0d got %h expected %h", name, p, inst, e_inst[p]);
        end
        checks++;
        if (busy !== e_busy[p]) begin
          errors++;
          $display("FAIL %s busy p=%0d got %b expected %b", name, p, busy, e_busy[p]);
        end
        checks++;
        if (in_ready !== e_rdy[p]) begin
          errors++;
          $display("FAIL %s in_ready p=%0d got %b expected %b", name, p, in_ready, e_rdy[p]);
        end
        checks++;
        if (done !== e_done[p]) begin
          errors++;
          $display("FAIL %s done p=%0d got %b expected %b", name, p, done, e_done[p]);
        end
        if (e_mchk[p]) begin
          checks++;
          if (mem_in !== e_mem[p]) begin
            errors++;
            $display("FAIL %s mem_in p=%0d got %h expected %h", name, p, mem_in, e_mem[p]);
          end
        end
      end
    end
    @(posedge clk);
    #1;
    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    $display("job %s k_len=%0d q_len=%0d periods=%0d errors_in_job=%0d",
             name, kl_in, ql_in, endp + 1, errors - jerr);
  endtask

  task automatic test_reset();
    reset      = 1'b0;
    start      = 1'b1;
    in_valid   = 1'b1;
    fifo_valid = 1'b1;
    k_len      = 5'd8;
    q_len      = 5'd8;
    in_data    = {$urandom, $urandom};
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (inst !== '0 || mem_in !== '0 || busy !== 1'b0 || in_ready !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL reset cycle=%0d inst=%h mem_in=%h busy=%b rdy=%b done=%b expected all zero",
                 i, inst, mem_in, busy, in_ready, done);
      end
    end
    @(posedge clk);
    #1;
    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || inst !== '0) begin
      errors++;
      $display("FAIL reset_release busy=%b inst=%h expected 0 and 0", busy, inst);
    end
    $display("job reset checked");
  endtask

  task automatic test_basic();
    run_job("basic", 8, 8, 0, 0, 1'b0, -1);
  endtask

  task automatic test_backpressure();
    run_job("backpressure", 2, 1, 1, 0, 1'b0, -1);
  endtask

  task automatic test_boundary();
    run_job("len16_q1", 16, 1, 0, 0, 1'b0, -1);
    run_job("len0", 0, 3, 2, 0, 1'b0, -1);
    run_job("len_over", 20, 0, 0, 0, 1'b0, -1);
  endtask

  task automatic test_fifo_stall();
    run_job("fifo_stall", 4, 6, 0, 1, 1'b0, -1);
  endtask

  task automatic test_reset_mid_exe();
    run_job("reset_exe", 5, 6, 0, 0, 1'b0, 3);
    run_job("after_reset", 5, 6, 2, 2, 1'b0, -1);
  endtask

  task automatic test_start_busy();
    run_job("start_busy", 8, 8, 0, 0, 1'b1, -1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      run_job("random", int'($urandom_range(20, 0)), int'($urandom_range(20, 0)), 2, 2, 1'b0, -1);
    end
  endtask

  initial begin
    reset      = 1'b0;
    start      = 1'b0;
    k_len      = '0;
    q_len      = '0;
    in_data    = '0;
    in_valid   = 1'b0;
    fifo_valid = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_boundary();
    test_fifo_stall();
    test_reset_mid_exe();
    test_start_busy();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
